// File: rtl/sdram_traffic_checker.sv
// Self-checking SDRAM traffic engine. It writes a patterned block, reads it back with a
// bounded number of reads in flight, and counts mismatching in-order read responses.
module sdram_traffic_checker #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 4,
  parameter int ERR_W     = 16
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              req_valid,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              req_ready,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [2:0]        dbg_state
);

  localparam int OUTST_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    wi_q, wi_d;
  logic [CNT_W-1:0]    ri_q, ri_d;
  logic [CNT_W-1:0]    ci_q, ci_d;
  logic [OUTST_W-1:0]  outst_q, outst_d;
  logic                req_valid_q, req_valid_d;
  logic                req_write_q, req_write_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;

  logic                req_xfer;
  logic                slot_free;
  logic                in_check;
  logic                resp_ok;
  logic                err_hit;
  logic [ADDR_W-1:0]   err_addr;

  function automatic logic [DATA_W-1:0] pattern_f(input logic [1:0]        m,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic [CNT_W-1:0]  i);
    logic [CNT_W-1:0] sh;
    sh = i % CNT_W'(DATA_W);
    case (m)
      2'd0:    pattern_f = s + DATA_W'(i);
      2'd1:    pattern_f = ~(s + DATA_W'(i));
      2'd2:    pattern_f = DATA_W'(1) << sh;
      default: pattern_f = s;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] addr_f(input logic [ADDR_W-1:0] b,
                                               input logic [CNT_W-1:0]  i);
    addr_f = b + ADDR_W'(i);
  endfunction

  // Request handshake: a transfer happens on a rising edge with req_valid and req_ready
  // both high; once raised, req_valid and its payload hold until that transfer, and the
  // next request may be presented in the cycle right after it.
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    seed_d           = seed_q;
    base_d           = base_q;
    count_d          = count_q;
    wi_d             = wi_q;
    ri_d             = ri_q;
    ci_d             = ci_q;
    req_valid_d      = req_valid_q;
    req_write_d      = req_write_q;
    req_addr_d       = req_addr_q;
    req_wdata_d      = req_wdata_q;
    busy_d           = busy_q;
    done_d           = done_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    err_hit          = 1'b0;
    err_addr         = '0;

    req_xfer  = req_valid_q & req_ready;
    slot_free = ~req_valid_q | req_ready;
    in_check  = (state_q == READ) || (state_q == DRAIN);
    resp_ok   = rd_valid & in_check & (outst_q != '0);
    outst_d   = outst_q + OUTST_W'(req_xfer && !req_write_q) - OUTST_W'(resp_ok);

    // Any response with no read in flight is an error with no meaningful address.
    if (resp_ok) begin
      ci_d = ci_q + CNT_W'(1);
      if (rd_data != pattern_f(mode_q, seed_q, ci_q)) begin
        err_hit  = 1'b1;
        err_addr = addr_f(base_q, ci_q);
      end
    end else if (rd_valid) begin
      err_hit  = 1'b1;
      err_addr = '1;
    end

    if (err_hit) begin
      if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      if (err_count_q == '0) first_err_addr_d = err_addr;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d           = mode;
          seed_d           = seed;
          base_d           = base_addr;
          count_d          = count;
          wi_d             = '0;
          ri_d             = '0;
          ci_d             = '0;
          outst_d          = '0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          req_valid_d      = 1'b0;
          if (count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = WRITE;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      WRITE: begin
        if (slot_free) begin
          if (wi_q != count_q) begin
            req_valid_d = 1'b1;
            req_write_d = 1'b1;
            req_addr_d  = addr_f(base_q, wi_q);
            req_wdata_d = pattern_f(mode_q, seed_q, wi_q);
            wi_d        = wi_q + CNT_W'(1);
          end else begin
            req_valid_d = 1'b0;
            state_d     = READ;
          end
        end
      end

      READ: begin
        // outst_d already includes this cycle's transfer and response, so a response
        // arriving while the window is full re-opens it for the very next cycle.
        if (slot_free) begin
          if (ri_q == count_q) begin
            req_valid_d = 1'b0;
            state_d     = DRAIN;
          end else if (outst_d < OUTST_W'(MAX_OUTST)) begin
            req_valid_d = 1'b1;
            req_write_d = 1'b0;
            req_addr_d  = addr_f(base_q, ri_q);
            req_wdata_d = '0;
            ri_d        = ri_q + CNT_W'(1);
          end else begin
            req_valid_d = 1'b0;
          end
        end
      end

      DRAIN: begin
        if (outst_q == '0 && ci_q == count_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q          <= IDLE;
      mode_q           <= '0;
      seed_q           <= '0;
      base_q           <= '0;
      count_q          <= '0;
      wi_q             <= '0;
      ri_q             <= '0;
      ci_q             <= '0;
      outst_q          <= '0;
      req_valid_q      <= 1'b0;
      req_write_q      <= 1'b0;
      req_addr_q       <= '0;
      req_wdata_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      seed_q           <= seed_d;
      base_q           <= base_d;
      count_q          <= count_d;
      wi_q             <= wi_d;
      ri_q             <= ri_d;
      ci_q             <= ci_d;
      outst_q          <= outst_d;
      req_valid_q      <= req_valid_d;
      req_write_q      <= req_write_d;
      req_addr_q       <= req_addr_d;
      req_wdata_q      <= req_wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign req_valid      = req_valid_q;
  assign req_write      = req_write_q;
  assign req_addr       = req_addr_q;
  assign req_wdata      = req_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_count_q == '0);
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Bench for sdram_traffic_checker: memory model with configurable read latency and
// random back-pressure, request scoreboard, and end-of-run result checks.
module tb_sdram_traffic_checker;

  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 16;
  localparam int MAX_OUTST = 4;
  localparam int ERR_W     = 16;
  localparam int RQ_W      = 1 + ADDR_W + DATA_W;
  localparam int RSP_DEPTH = 1024;

  logic              m_clock = 1'b0;
  logic              p_reset;
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [2:0]        dbg_state;

  sdram_traffic_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_OUTST(MAX_OUTST), .ERR_W(ERR_W)
  ) dut (
    .m_clock(m_clock), .p_reset(p_reset), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .count(count), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 m_clock = ~m_clock;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- shared state ----------------
  int tests = 0;
  int failures = 0;
  logic [RQ_W-1:0]   exp_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int                rsp_due [RSP_DEPTH];
  logic [DATA_W-1:0] rsp_dat [RSP_DEPTH];
  int rsp_wr = 0;
  int rsp_rd = 0;
  int cyc = 0;
  int rd_lat = 3;
  bit ready_rand = 1'b0;
  bit corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  int spur_req = 0;
  int spur_done = 0;
  int tb_outst = 0;
  int max_outst = 0;
  int exp_err = 0;
  logic [ADDR_W-1:0] exp_first = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] ref_pattern(input int m, input logic [DATA_W-1:0] s,
                                                    input int i);
    logic [DATA_W-1:0] one;
    one = 1;
    case (m)
      0:       return s + DATA_W'(i);
      1:       return ~(s + DATA_W'(i));
      2:       return one << (i % DATA_W);
      default: return s;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] ref_addr(input logic [ADDR_W-1:0] b, input int i);
    return b + ADDR_W'(i);
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = mem.exists(a) ? mem[a] : '0;
    if (corrupt_en && a == corrupt_addr) d = d ^ DATA_W'(1);
    return d;
  endfunction

  // ---------------- memory model and bus driver ----------------
  task automatic mem_model();
    forever begin
      @(negedge m_clock);
      if (!p_reset && req_valid && req_ready) begin
        if (req_write) mem[req_addr] = req_wdata;
        else begin
          rsp_due[rsp_wr % RSP_DEPTH] = cyc + rd_lat;
          rsp_dat[rsp_wr % RSP_DEPTH] = mem_rd(req_addr);
          rsp_wr++;
        end
      end
    end
  endtask

  task automatic bus_driver();
    forever begin
      @(posedge m_clock);
      #1;
      cyc++;
      req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_valid  = 1'b0;
      rd_data   = '0;
      if (p_reset) rsp_rd = rsp_wr;
      else if (rsp_rd != rsp_wr && rsp_due[rsp_rd % RSP_DEPTH] <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = rsp_dat[rsp_rd % RSP_DEPTH];
        rsp_rd++;
      end else if (spur_req != spur_done) begin
        rd_valid = 1'b1;
        rd_data  = DATA_W'($urandom);
        spur_done++;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic [RQ_W-1:0] act, prev_pl, exp;
    bit prev_stall;
    int nxt;
    prev_stall = 1'b0;
    prev_pl = '0;
    forever begin
      @(negedge m_clock);
      act = {req_write, req_addr, req_wdata};
      if (p_reset) begin
        prev_stall = 1'b0;
        tb_outst   = 0;
      end else begin
        if (prev_stall) check("req_hold", {req_valid, act}, {1'b1, prev_pl});
        if (req_valid && req_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL req_unexpected: got {w,addr,data}=0x%0h, expected no request", act);
          end else begin
            exp = exp_q.pop_front();
            check("req", act, exp);
          end
        end
        nxt = tb_outst + ((req_valid && req_ready && !req_write) ? 1 : 0)
                       - ((rd_valid && tb_outst > 0) ? 1 : 0);
        tb_outst = nxt;
        if (nxt > max_outst) max_outst = nxt;
        prev_stall = req_valid && !req_ready;
        prev_pl    = act;
      end
    end
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic pulse_start(input int m, input logic [DATA_W-1:0] s,
                             input logic [ADDR_W-1:0] b, input int n);
    @(posedge m_clock);
    #1;
    mode      = 2'(m);
    seed      = s;
    base_addr = b;
    count     = CNT_W'(n);
    start     = 1'b1;
    @(posedge m_clock);
    #1;
    start = 1'b0;
  endtask

  task automatic start_run(input int m, input logic [DATA_W-1:0] s,
                           input logic [ADDR_W-1:0] b, input int n);
    logic [DATA_W-1:0] p, got;
    exp_err   = 0;
    exp_first = '0;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, ref_addr(b, i), ref_pattern(m, s, i)});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, ref_addr(b, i), {DATA_W{1'b0}}});
      p   = ref_pattern(m, s, i);
      got = (corrupt_en && ref_addr(b, i) == corrupt_addr) ? (p ^ DATA_W'(1)) : p;
      if (got != p) begin
        if (exp_err == 0) exp_first = ref_addr(b, i);
        exp_err++;
      end
    end
    max_outst = 0;
    pulse_start(m, s, b, n);
  endtask

  task automatic finish_run(input string name, input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge m_clock);
      c++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_err_count"}, err_count, exp_err);
    check({name, "_first_err_addr"}, first_err_addr, exp_first);
    check({name, "_pass"}, pass, (exp_err == 0));
    check({name, "_reqs_left"}, exp_q.size(), 0);
    check({name, "_outst_le_max"}, (max_outst <= MAX_OUTST), 1);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_valid"}, req_valid, 0);
    check({name, "_req_write"}, req_write, 0);
    check({name, "_req_addr"}, req_addr, 0);
    check({name, "_req_wdata"}, req_wdata, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_pass"}, pass, 0);
    check({name, "_err_count"}, err_count, 0);
    check({name, "_first_err_addr"}, first_err_addr, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] rs;
    logic [ADDR_W-1:0] rb;
    int m, n, c;

    p_reset = 1'b1; start = 1'b0; mode = '0; seed = '0; base_addr = '0; count = '0;
    req_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    fork
      monitor();
      mem_model();
      bus_driver();
    join_none

    repeat (3) @(posedge m_clock);
    #2;
    check_reset_outputs("reset");
    @(posedge m_clock);
    #3;
    p_reset = 1'b0;

    // Directed incrementing pattern, ideal memory.
    rd_lat = 3; ready_rand = 1'b0;
    start_run(0, 16'h1000, 22'h100, 8);
    finish_run("basic", 400);

    // Same run with one corrupted word.
    corrupt_en = 1'b1; corrupt_addr = 22'h103;
    start_run(0, 16'h1000, 22'h100, 8);
    finish_run("corrupt", 400);
    corrupt_en = 1'b0;

    // Walking-one pattern under random back-pressure.
    ready_rand = 1'b1;
    rs = DATA_W'($urandom); rb = ADDR_W'($urandom);
    start_run(2, rs, rb, 100);
    finish_run("walk_bp", 4000);

    // Randomised runs: mode, length, latency, back-pressure and corruption.
    for (int k = 0; k < 6; k++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(1, 40);
      rs = DATA_W'($urandom); rb = ADDR_W'($urandom);
      rd_lat = $urandom_range(1, 8);
      ready_rand = 1'($urandom_range(0, 1));
      corrupt_en = 1'($urandom_range(0, 1));
      corrupt_addr = ref_addr(rb, $urandom_range(0, n - 1));
      start_run(m, rs, rb, n);
      finish_run("random", 2000);
    end
    corrupt_en = 1'b0;

    // Address wrap past the top of the address space.
    rd_lat = 3; ready_rand = 1'b0;
    rs = DATA_W'($urandom);
    start_run(0, rs, 22'h3FFFFE, 4);
    finish_run("wrap", 400);

    // Zero-length run completes without any request.
    start_run(1, rs, 22'h0, 0);
    finish_run("zero", 2);

    // A start pulse during a run must be ignored.
    rs = DATA_W'($urandom);
    start_run(1, rs, 22'h2000, 20);
    repeat (6) @(posedge m_clock);
    pulse_start(0, 16'hABCD, 22'h55, 3);
    finish_run("busy_start", 1000);

    // Reset in the middle of the read phase with three reads in flight.
    rd_lat = 12; ready_rand = 1'b0;
    start_run(0, 16'h4000, 22'h200, 8);
    c = 0;
    while (tb_outst < 3 && c < 300) begin
      @(posedge m_clock);
      #2;
      c++;
    end
    check("reached_3_outstanding", (tb_outst >= 3), 1);
    p_reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge m_clock);
    #3;
    p_reset = 1'b0;

    // Spurious read data while idle.
    repeat (2) @(posedge m_clock);
    spur_req++;
    repeat (4) @(posedge m_clock);
    #2;
    check("spur_err_count", err_count, 1);
    check("spur_first_err_addr", first_err_addr, 22'h3FFFFF);
    check("spur_busy", busy, 0);
    check("spur_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
